u_wb_fwd_buf: RTL and testbench
===============================

Name: u_wb_fwd_buf

Overview:
- Parametrised write-back/forwarding buffer for the execute/write-back path of the RV32 pipeline.
- Holds in-flight register-file writes in a DEPTH-entry shift pipeline, forwards the youngest matching data to NRD read ports, and retires the oldest entry to the register file.
- Extends the fixed 3-deep, 2-port buffer with configurable depth and port count, load-pending entries filled later by the LSU, and back-pressure when a pending load reaches retirement.

Parameters:
DEPTH, 3, number of buffer stages (>=2); stage DEPTH-1 drives the register-file write port
NRD, 2, number of forwarding read ports
AW, 5, register address width
DW, 32, data width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
flush  input  1  kill the incoming write this cycle (in_vld ignored)
in_vld  input  1  new write from execute
in_pend  input  1  new write is a load; data arrives later via fill
in_a  input  AW  destination register
in_d  input  DW  write data (ignored when in_pend=1)
in_rdy  output  1  buffer accepts input this cycle (= shift enable)
fill_vld  input  1  LSU load data valid
fill_d  input  DW  LSU load data
rd_a  input  NRD*AW  read-port addresses, port i at [i*AW +: AW]
rd_d  output  NRD*DW  forwarded data, port i at [i*DW +: DW]
rd_hit  output  NRD  port i matches a valid, non-pending entry
rd_busy  output  NRD  port i's youngest match is pending (caller must stall)
wb_e  output  1  register-file write enable
wb_a  output  AW  register-file write address
wb_d  output  DW  register-file write data
occ  output  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Entry fields: vld, pend, a, d. Stage 0 is youngest, stage DEPTH-1 is oldest.
- Reset (async, rst=1): all entries vld=0, pend=0, a=0, d=0. Outputs wb_e=0, wb_a=0, wb_d=0, rd_*=0, occ=0, in_rdy=1.
- shift = !(vld[DEPTH-1] & pend[DEPTH-1]); in_rdy = shift.
- When shift=1, each clock:
  - stage k+1 <= stage k.
  - stage 0 <= {in_vld & !flush & in_a!=0, in_pend, in_a, in_d}. An in_a=0 or flushed write enters as vld=0, a=0.
- When shift=0: all stages hold and in_* is ignored. The producer must hold its input until in_rdy=1.
- Fill: on fill_vld, the oldest entry with vld & pend (highest index) takes d=fill_d, pend=0. The fill is applied in that entry's next position if a shift occurs the same cycle.
  - A fill with no pending entry is dropped.
  - At most one fill per cycle.
- Retire (combinational from stage DEPTH-1): wb_e = vld & !pend, wb_a = a, wb_d = d.
  - A filled oldest entry writes on the cycle after the fill, then shifts out.
- Forwarding (combinational, per port i):
  - Scan stages 0..DEPTH-1; the first match with vld & a==rd_a[i] is selected.
  - Selected entry non-pending: rd_hit[i]=1, rd_d[i]=d, rd_busy[i]=0.
  - Selected entry pending: rd_busy[i]=1, rd_hit[i]=0, rd_d[i]=0.
  - No match, or rd_a[i]=0: all three outputs are 0.
- occ = popcount(vld), registered. Range 0..DEPTH; it never wraps.
- Reset mid-operation clears all entries immediately, including pending ones. A fill arriving after reset is dropped.

Optional Feature:
- Macro: WBBUF_BYPASS_EN.
- Defined: the current-cycle input (in_vld & !flush & in_rdy & in_a!=0) is treated as a stage -1 entry and takes priority over stage 0 in forwarding. A pending input sets rd_busy.
- Undefined: forwarding sees registered entries only.

Test Plan:
- Reset, then in {vld=1, a=5, d=0x11}, DEPTH=3 -> wb_e=1, wb_a=5, wb_d=0x11 exactly 3 cycles after the input edge; occ goes 1, 1, 1 then 0 with no further input.
- Write a=7 d=0xA then a=7 d=0xB on consecutive cycles; port 0 rd_a=7 -> rd_d=0xB, rd_hit=1 while both are resident; after 0xB retires -> rd_hit=0.
- Pending load a=3 reaches stage DEPTH-1 with no fill -> in_rdy=0, wb_e=0, rd_busy for rd_a=3 is 1. fill_vld with fill_d=0x55 -> next cycle wb_e=1, wb_d=0x55; the cycle after, in_rdy=1.
- in_a=0 and flush=1 with in_vld=1 -> no entry created, occ unchanged, wb_e never asserts.
- Fill on the same cycle a pending entry shifts from stage 0 to 1 -> stage 1 holds fill_d with pend=0; rd_hit=1 next cycle.
- rst asserted with 3 valid entries, one pending -> occ=0, wb_e=0, rd_hit=0 and rd_busy=0 immediately; a fill after reset has no effect.

Source files
------------

// File: rtl/u_wb_fwd_buf.sv
// Write-back/forwarding buffer: DEPTH-stage shift pipeline of pending RF writes with
// youngest-match forwarding and LSU fill. Optional current-cycle bypass: WBBUF_BYPASS_EN.

module u_wb_fwd_buf_port #(
    parameter int DEPTH = 3,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic [AW-1:0]             rd_a,
    input  logic [DEPTH-1:0]          vld,
    input  logic [DEPTH-1:0]          pend,
    input  logic [DEPTH-1:0][AW-1:0]  a,
    input  logic [DEPTH-1:0][DW-1:0]  d,
    input  logic                      byp_vld,
    input  logic                      byp_pend,
    input  logic [AW-1:0]             byp_a,
    input  logic [DW-1:0]             byp_d,
    output logic [DW-1:0]             rd_d,
    output logic                      rd_hit,
    output logic                      rd_busy
);
    logic          sel_vld;
    logic          sel_pend;
    logic [DW-1:0] sel_d;

    always_comb begin
        sel_vld  = 1'b0;
        sel_pend = 1'b0;
        sel_d    = '0;
        // walk oldest to youngest so the youngest match is left standing
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (vld[k] && a[k] == rd_a) begin
                sel_vld  = 1'b1;
                sel_pend = pend[k];
                sel_d    = d[k];
            end
        end
        if (byp_vld && byp_a == rd_a) begin
            sel_vld  = 1'b1;
            sel_pend = byp_pend;
            sel_d    = byp_d;
        end
        if (rd_a == '0) sel_vld = 1'b0;
    end

    assign rd_hit  = sel_vld & ~sel_pend;
    assign rd_busy = sel_vld & sel_pend;
    assign rd_d    = rd_hit ? sel_d : '0;
endmodule

module u_wb_fwd_buf #(
    parameter int DEPTH = 3,
    parameter int NRD   = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_vld,
    input  logic                        in_pend,
    input  logic [AW-1:0]               in_a,
    input  logic [DW-1:0]               in_d,
    output logic                        in_rdy,
    input  logic                        fill_vld,
    input  logic [DW-1:0]               fill_d,
    input  logic [NRD*AW-1:0]           rd_a,
    output logic [NRD*DW-1:0]           rd_d,
    output logic [NRD-1:0]              rd_hit,
    output logic [NRD-1:0]              rd_busy,
    output logic                        wb_e,
    output logic [AW-1:0]               wb_a,
    output logic [DW-1:0]               wb_d,
    output logic [$clog2(DEPTH+1)-1:0]  occ
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]         vld, pend, vld_n, pend_n;
    logic [DEPTH-1:0][AW-1:0] a, a_n;
    logic [DEPTH-1:0][DW-1:0] d, d_n;
    logic [OW-1:0]            occ_n;
    logic                     shift, new_vld, fill_hit, byp_vld;
    logic [AW-1:0]            new_a;
    int                       fill_idx, fill_tgt;

    // a pending load parked in the retire slot freezes the whole pipe
    assign shift   = ~(vld[DEPTH-1] & pend[DEPTH-1]);
    assign in_rdy  = shift;
    assign new_vld = in_vld & ~flush & (in_a != '0);
    assign new_a   = new_vld ? in_a : '0;

    always_comb begin
        fill_hit = 1'b0;
        fill_idx = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[k] && pend[k]) begin
                fill_hit = 1'b1;
                fill_idx = k;
            end
        end
    end

    always_comb begin
        vld_n    = vld;
        pend_n   = pend;
        a_n      = a;
        d_n      = d;
        occ_n    = '0;
        fill_tgt = fill_idx + (shift ? 1 : 0);
        if (shift) begin
            vld_n  = {vld[DEPTH-2:0], new_vld};
            pend_n = {pend[DEPTH-2:0], in_pend};
            a_n    = {a[DEPTH-2:0], new_a};
            d_n    = {d[DEPTH-2:0], in_d};
        end
        // the fill lands wherever the target entry sits after this edge
        for (int k = 0; k < DEPTH; k++) begin
            if (fill_vld && fill_hit && k == fill_tgt) begin
                pend_n[k] = 1'b0;
                d_n[k]    = fill_d;
            end
        end
        for (int k = 0; k < DEPTH; k++) occ_n = occ_n + OW'(vld_n[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= '0;
            pend <= '0;
            a    <= '0;
            d    <= '0;
            occ  <= '0;
        end else begin
            vld  <= vld_n;
            pend <= pend_n;
            a    <= a_n;
            d    <= d_n;
            occ  <= occ_n;
        end
    end

    assign wb_e = vld[DEPTH-1] & ~pend[DEPTH-1];
    assign wb_a = a[DEPTH-1];
    assign wb_d = d[DEPTH-1];

`ifdef WBBUF_BYPASS_EN
    assign byp_vld = new_vld & shift;
`else
    assign byp_vld = 1'b0;
`endif

    for (genvar g = 0; g < NRD; g++) begin : g_port
        u_wb_fwd_buf_port #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_port (
            .rd_a     (rd_a[g*AW +: AW]),
            .vld      (vld),
            .pend     (pend),
            .a        (a),
            .d        (d),
            .byp_vld  (byp_vld),
            .byp_pend (in_pend),
            .byp_a    (in_a),
            .byp_d    (in_d),
            .rd_d     (rd_d[g*DW +: DW]),
            .rd_hit   (rd_hit[g]),
            .rd_busy  (rd_busy[g])
        );
    end
endmodule

// File: tb/tb_u_wb_fwd_buf.sv
// Self-checking bench for u_wb_fwd_buf: directed literal cases plus randomized traffic
// compared every cycle against a list-of-entries model.
module tb_u_wb_fwd_buf;
    localparam int D  = 3;
    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst, flush, in_vld, in_pend, fill_vld;
    logic [AW-1:0]   in_a;
    logic [DW-1:0]   in_d, fill_d;
    logic [N*AW-1:0] rd_a;
    logic            in_rdy, wb_e;
    logic [N*DW-1:0] rd_d;
    logic [N-1:0]    rd_hit, rd_busy;
    logic [AW-1:0]   wb_a;
    logic [DW-1:0]   wb_d;
    logic [1:0]      occ;

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    u_wb_fwd_buf #(.DEPTH(D), .NRD(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_pend(in_pend),
        .in_a(in_a), .in_d(in_d), .in_rdy(in_rdy), .fill_vld(fill_vld), .fill_d(fill_d),
        .rd_a(rd_a), .rd_d(rd_d), .rd_hit(rd_hit), .rd_busy(rd_busy),
        .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d), .occ(occ)
    );

    // model: list of in-flight writes, index 0 youngest
    typedef struct packed {
        logic          v;
        logic          p;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t m [D];
    ent_t m_n [D];

    always_comb begin
        int f;
        logic stall;
        m_n   = m;
        f     = -1;
        for (int i = 0; i < D; i++) if (m[i].v && m[i].p) f = i;
        stall = m[D-1].v && m[D-1].p;
        if (fill_vld && f >= 0) begin
            m_n[f].p = 1'b0;
            m_n[f].d = fill_d;
        end
        if (!stall) begin
            for (int i = D - 1; i > 0; i--) m_n[i] = m_n[i-1];
            m_n[0].v = in_vld && !flush && in_a != '0;
            m_n[0].p = in_pend;
            m_n[0].a = (in_vld && !flush && in_a != '0) ? in_a : '0;
            m_n[0].d = in_d;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) for (int i = 0; i < D; i++) m[i] <= '0;
        else     for (int i = 0; i < D; i++) m[i] <= m_n[i];
    end

    logic            e_rdy, e_wbe;
    logic [AW-1:0]   e_wba;
    logic [DW-1:0]   e_wbd;
    logic [1:0]      e_occ;
    logic [N*DW-1:0] e_rdd;
    logic [N-1:0]    e_hit, e_busy;

    always_comb begin
        logic          fnd;
        logic [AW-1:0] ra;
        e_rdy  = !(m[D-1].v && m[D-1].p);
        e_wbe  = m[D-1].v && !m[D-1].p;
        e_wba  = m[D-1].a;
        e_wbd  = m[D-1].d;
        e_occ  = '0;
        e_rdd  = '0;
        e_hit  = '0;
        e_busy = '0;
        for (int i = 0; i < D; i++) e_occ = e_occ + {1'b0, m[i].v};
        for (int j = 0; j < N; j++) begin
            ra  = rd_a[j*AW +: AW];
            fnd = (ra == '0);
`ifdef WBBUF_BYPASS_EN
            if (!fnd && in_vld && !flush && e_rdy && in_a == ra) begin
                fnd       = 1'b1;
                e_busy[j] = in_pend;
                e_hit[j]  = !in_pend;
                if (!in_pend) e_rdd[j*DW +: DW] = in_d;
            end
`endif
            for (int i = 0; i < D; i++) begin
                if (!fnd && m[i].v && m[i].a == ra) begin
                    fnd       = 1'b1;
                    e_busy[j] = m[i].p;
                    e_hit[j]  = !m[i].p;
                    if (!m[i].p) e_rdd[j*DW +: DW] = m[i].d;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_rdy",  64'(in_rdy),  64'(e_rdy));
            chk("wb_e",    64'(wb_e),    64'(e_wbe));
            chk("wb_a",    64'(wb_a),    64'(e_wba));
            chk("wb_d",    64'(wb_d),    64'(e_wbd));
            chk("occ",     64'(occ),     64'(e_occ));
            chk("rd_d",    64'(rd_d),    64'(e_rdd));
            chk("rd_hit",  64'(rd_hit),  64'(e_hit));
            chk("rd_busy", 64'(rd_busy), 64'(e_busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_vld   = 1'b0;
        in_pend  = 1'b0;
        flush    = 1'b0;
        fill_vld = 1'b0;
        in_a     = '0;
        in_d     = '0;
    endtask

    initial begin
        rst = 1'b1; rd_a = '0; fill_d = '0;
        idle();
        tick();
        chk("rst_occ",  64'(occ),    64'd0);
        chk("rst_rdy",  64'(in_rdy), 64'd1);
        chk("rst_wbe",  64'(wb_e),   64'd0);
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // single write retires from the last stage
        in_vld = 1'b1; in_a = 5'd5; in_d = 32'h11;
        tick(); idle(); #1;
        chk("t1_occ_a", 64'(occ), 64'd1);
        chk("t1_wbe_a", 64'(wb_e), 64'd0);
        tick(); #1;
        chk("t1_occ_b", 64'(occ), 64'd1);
        tick(); #1;
        chk("t1_wbe", 64'(wb_e), 64'd1);
        chk("t1_wba", 64'(wb_a), 64'd5);
        chk("t1_wbd", 64'(wb_d), 64'h11);
        chk("t1_occ_c", 64'(occ), 64'd1);
        tick(); #1;
        chk("t1_occ_d", 64'(occ), 64'd0);

        // youngest of two same-address writes forwards
        rd_a = {5'd0, 5'd7};
        in_vld = 1'b1; in_a = 5'd7; in_d = 32'hA;
        tick(); in_d = 32'hB;
        tick(); idle(); #1;
        chk("t2_d", 64'(rd_d[DW-1:0]), 64'hB);
        chk("t2_hit", 64'(rd_hit[0]), 64'd1);
        tick(); tick(); #1;
        chk("t2_d_old", 64'(rd_d[DW-1:0]), 64'hB);
        tick(); #1;
        chk("t2_gone", 64'(rd_hit[0]), 64'd0);

        // pending load stalls at retire until filled
        rd_a = {5'd0, 5'd3};
        in_vld = 1'b1; in_pend = 1'b1; in_a = 5'd3;
        tick(); idle(); tick(); tick(); #1;
        chk("t3_rdy", 64'(in_rdy), 64'd0);
        chk("t3_wbe", 64'(wb_e), 64'd0);
        chk("t3_busy", 64'(rd_busy[0]), 64'd1);
        tick(); #1;
        chk("t3_rdy_hold", 64'(in_rdy), 64'd0);
        fill_vld = 1'b1; fill_d = 32'h55;
        tick(); idle(); #1;
        chk("t3_wbe_f", 64'(wb_e), 64'd1);
        chk("t3_wbd_f", 64'(wb_d), 64'h55);
        tick(); #1;
        chk("t3_rdy_after", 64'(in_rdy), 64'd1);

        // a=0 and flushed writes create nothing
        in_vld = 1'b1; in_a = 5'd0; in_d = 32'h1;
        tick(); in_a = 5'd9; flush = 1'b1;
        tick(); idle(); #1;
        chk("t4_occ", 64'(occ), 64'd0);
        tick(); tick(); tick(); #1;
        chk("t4_occ2", 64'(occ), 64'd0);

        // fill while the pending entry shifts 0 -> 1
        rd_a = {5'd0, 5'd4};
        in_vld = 1'b1; in_pend = 1'b1; in_a = 5'd4;
        tick(); idle(); fill_vld = 1'b1; fill_d = 32'h77;
        tick(); idle(); #1;
        chk("t5_hit", 64'(rd_hit[0]), 64'd1);
        chk("t5_busy", 64'(rd_busy[0]), 64'd0);
        chk("t5_d", 64'(rd_d[DW-1:0]), 64'h77);
        repeat (3) tick();

        // async reset with a full buffer including a pending load
        rd_a = {5'd2, 5'd6};
        in_vld = 1'b1; in_a = 5'd1; in_d = 32'h1;
        tick(); in_a = 5'd2; in_pend = 1'b1;
        tick(); in_a = 5'd6; in_pend = 1'b0; in_d = 32'h66;
        tick(); idle(); #1;
        chk("t6_occ", 64'(occ), 64'd3);
        chk("t6_hit", 64'(rd_hit), 64'b01);
        chk("t6_busy", 64'(rd_busy), 64'b10);
        #2 rst = 1'b1;
        #1;
        chk("t6_r_occ", 64'(occ), 64'd0);
        chk("t6_r_wbe", 64'(wb_e), 64'd0);
        chk("t6_r_hit", 64'(rd_hit), 64'd0);
        chk("t6_r_busy", 64'(rd_busy), 64'd0);
        tick(); rst = 1'b0;
        fill_vld = 1'b1; fill_d = 32'h99;
        tick(); idle(); #1;
        chk("t6_f_occ", 64'(occ), 64'd0);
        chk("t6_f_wbe", 64'(wb_e), 64'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 399) == 0);
            in_vld   = ($urandom_range(0, 3) != 0);
            in_pend  = ($urandom_range(0, 9) < 3);
            flush    = ($urandom_range(0, 9) == 0);
            in_a     = AW'($urandom_range(0, 7));
            in_d     = $urandom;
            fill_vld = ($urandom_range(0, 9) < 3);
            fill_d   = $urandom;
            rd_a     = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            tick();
        end
        rst = 1'b0;
        idle();
        fill_vld = 1'b1;
        repeat (6) tick();
        idle();
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
